uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling, 3-sample majority vote) feeding a
// first-word-fall-through FIFO with a valid/ready consumer port.
module uart_rx_fifo #(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_AW     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic [7:0]         data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic [FIFO_AW:0]   count
);

  localparam int DIV_RAW = (INPUT_CLOCK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic               rx_meta_reg, rx_s;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic               tick;
  state_t             state_reg;
  logic [3:0]         sample_cnt_reg, sample_next;
  logic [2:0]         bit_cnt_reg;
  logic [7:0]         shift_reg;
  logic               s7_reg, s8_reg, majority;
  logic               push, pop, full, wr_en;
  logic [FIFO_AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [7:0]         mem [DEPTH];
  logic               overrun_reg, frame_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  // Free-running oversample divider; start detection never realigns it.
  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || tick) div_cnt_reg <= '0;
    else                div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  assign sample_next = sample_cnt_reg + 4'd1;
  // The third vote is the live sample taken on the decision tick itself.
  assign majority = (s7_reg & s8_reg) | (s7_reg & rx_s) | (s8_reg & rx_s);
  assign push     = tick && (state_reg == STOP) && (sample_next == 4'd9) && majority;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= 4'd0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      s7_reg         <= 1'b1;
      s8_reg         <= 1'b1;
      frame_err_reg  <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (tick) begin
        sample_cnt_reg <= sample_next;
        if (sample_next == 4'd7) s7_reg <= rx_s;
        if (sample_next == 4'd8) s8_reg <= rx_s;
        case (state_reg)
          IDLE: begin
            if (!rx_s) begin
              state_reg      <= START;
              sample_cnt_reg <= 4'd0;
            end
          end
          START: begin
            if (sample_next == 4'd9 && majority) begin
              state_reg <= IDLE;
            end else if (sample_next == 4'd15) begin
              state_reg   <= DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          DATA: begin
            if (sample_next == 4'd9) shift_reg <= {majority, shift_reg[7:1]};
            if (sample_next == 4'd15) begin
              if (bit_cnt_reg == 3'd7) state_reg <= STOP;
              else                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
          STOP: begin
            // Leaving at mid-stop gives half a bit of margin to catch the next start edge.
            if (sample_next == 4'd9) begin
              if (majority) begin
                state_reg <= IDLE;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= BREAK;
              end
            end
          end
          BREAK: begin
            if (rx_s) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign data_valid = (wr_ptr_reg != rd_ptr_reg);
  assign full       = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                      (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign pop        = data_valid && data_ready;
  assign wr_en      = push && (!full || pop);
  assign data_out   = data_valid ? mem[rd_ptr_reg[FIFO_AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[FIFO_AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push && full && !pop;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
